// File: rtl/nlfsr_selector.sv
// rtl/nlfsr_selector.sv - enumerates NLFSR feedback candidates and sequences the period checker
// Optional watchdog in RUN is enabled by defining SEL_TIMEOUT_EN (adds timeout_cnt port).
module nlfsr_selector #(
    parameter int SIZE  = 32,
    parameter int TAP_W = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [SIZE-1:0]      nlfsr_state,
    input  logic                 nlfsr_found,
    input  logic                 nlfsr_failure,
    output logic                 nlfsr_res,
    output logic                 nlfsr_ena,
    output logic                 selector_done,
    output logic                 feedback,
    output logic                 cand_valid,
    input  logic                 cand_ready,
    output logic [4*TAP_W-1:0]   cand_taps,
    output logic [15:0]          found_cnt,
`ifdef SEL_TIMEOUT_EN
    output logic [15:0]          timeout_cnt,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam int CW = 4 * TAP_W;
    localparam logic [TAP_W:0] SIZE_W = (TAP_W + 1)'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NRES,
        S_RUN,
        S_REPORT,
        S_ADV,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   code_q, code_d;
    logic [CW-1:0]   taps_q, taps_d;
    logic            nlfsr_res_q;
    logic            nlfsr_ena_q;
    logic            sel_done_q;
    logic            cand_valid_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     found_cnt_q;
    logic            wd_expired;

    // Code fields {b,a,t1,t0}; t0 occupies the low bits so it advances fastest.
    logic [TAP_W-1:0] c_t0, c_t1, c_a, c_b;
    logic [TAP_W-1:0] r_t0, r_t1, r_a, r_b;
    logic             code_valid;

    assign c_t0 = code_q[TAP_W-1:0];
    assign c_t1 = code_q[2*TAP_W-1:TAP_W];
    assign c_a  = code_q[3*TAP_W-1:2*TAP_W];
    assign c_b  = code_q[4*TAP_W-1:3*TAP_W];

    assign r_t0 = taps_q[TAP_W-1:0];
    assign r_t1 = taps_q[2*TAP_W-1:TAP_W];
    assign r_a  = taps_q[3*TAP_W-1:2*TAP_W];
    assign r_b  = taps_q[4*TAP_W-1:3*TAP_W];

    assign code_valid = (c_t0 != '0) && (c_a != '0) && (c_t0 < c_t1) && (c_a < c_b) &&
                        ({1'b0, c_t0} < SIZE_W) && ({1'b0, c_t1} < SIZE_W) &&
                        ({1'b0, c_a} < SIZE_W) && ({1'b0, c_b} < SIZE_W);

`ifdef SEL_TIMEOUT_EN
    localparam int WD_W = SIZE + 2;
    // Last RUN cycle index before expiry: the watchdog spans 2^SIZE+8 cycles.
    localparam logic [WD_W-1:0] WD_LAST = (WD_W'(1) << SIZE) + WD_W'(7);

    logic [WD_W-1:0] wd_q;
    logic [15:0]     timeout_cnt_q;

    assign wd_expired  = (wd_q == WD_LAST);
    assign timeout_cnt = timeout_cnt_q;

    always_ff @(posedge clk) begin
        if (res) begin
            wd_q          <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (state_q == S_NRES) begin
                wd_q <= '0;
            end else if (state_q == S_RUN) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if ((state_q == S_RUN) && !nlfsr_found && !nlfsr_failure && wd_expired &&
                (timeout_cnt_q != 16'hFFFF)) begin
                timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        taps_d  = taps_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    code_d  = '0;
                end
            end
            S_LOAD: begin
                if (code_valid) begin
                    taps_d  = code_q;
                    state_d = S_NRES;
                end else if (&code_q) begin
                    state_d = S_FIN;
                end else begin
                    code_d = code_q + CW'(1);
                end
            end
            S_NRES: state_d = S_RUN;
            S_RUN: begin
                if (nlfsr_found) begin
                    state_d = S_REPORT;
                end else if (nlfsr_failure || wd_expired) begin
                    state_d = S_ADV;
                end
            end
            S_REPORT: begin
                if (cand_ready) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (&code_q) begin
                    state_d = S_FIN;
                end else begin
                    code_d  = code_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            code_q       <= '0;
            taps_q       <= '0;
            nlfsr_res_q  <= 1'b1;
            nlfsr_ena_q  <= 1'b0;
            sel_done_q   <= 1'b0;
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            taps_q       <= taps_d;
            nlfsr_res_q  <= (state_d == S_IDLE) || (state_d == S_NRES);
            nlfsr_ena_q  <= (state_d == S_RUN);
            sel_done_q   <= (state_d == S_RUN);
            cand_valid_q <= (state_d == S_REPORT);
            busy_q       <= !((state_d == S_IDLE) || (state_d == S_FIN));
            if (state_d == S_FIN) begin
                done_q <= 1'b1;
            end else if ((state_q == S_IDLE) && start) begin
                done_q <= 1'b0;
            end
            if ((state_q == S_REPORT) && cand_ready && (found_cnt_q != 16'hFFFF)) begin
                found_cnt_q <= found_cnt_q + 16'd1;
            end
        end
    end

    assign feedback = sel_done_q &
                      (nlfsr_state[r_t0] ^ nlfsr_state[r_t1] ^ (nlfsr_state[r_a] & nlfsr_state[r_b]));

    assign nlfsr_res     = nlfsr_res_q;
    assign nlfsr_ena     = nlfsr_ena_q;
    assign selector_done = sel_done_q;
    assign cand_valid    = cand_valid_q;
    assign cand_taps     = taps_q;
    assign found_cnt     = found_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_nlfsr_selector.sv
// tb/tb_nlfsr_selector.sv - table-driven scoreboard bench for nlfsr_selector at SIZE=4
module tb_nlfsr_selector;

    localparam int SIZE = 4;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            res;
    logic            start;
    logic [SIZE-1:0] nlfsr_state;
    logic            nlfsr_found;
    logic            nlfsr_failure;
    logic            nlfsr_res;
    logic            nlfsr_ena;
    logic            selector_done;
    logic            feedback;
    logic            cand_valid;
    logic            cand_ready;
    logic [CW-1:0]   cand_taps;
    logic [15:0]     found_cnt;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    nlfsr_selector #(.SIZE(SIZE)) dut (
        .clk           (clk),
        .res           (res),
        .start         (start),
        .nlfsr_state   (nlfsr_state),
        .nlfsr_found   (nlfsr_found),
        .nlfsr_failure (nlfsr_failure),
        .nlfsr_res     (nlfsr_res),
        .nlfsr_ena     (nlfsr_ena),
        .selector_done (selector_done),
        .feedback      (feedback),
        .cand_valid    (cand_valid),
        .cand_ready    (cand_ready),
        .cand_taps     (cand_taps),
        .found_cnt     (found_cnt),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [8:0] found_m;
        logic [8:0] fail_m;
        int         hold;
        int         exp_found;
    } vec_t;

    vec_t          tbl [6];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_codes [$];
    logic [CW-1:0] exp_nres [$];
    logic [CW-1:0] cand_q [$];
    logic [8:0]    cur_found_m = '0;
    logic [8:0]    cur_fail_m = '0;
    int            cur_hold = 0;
    int            nres_cnt = 0;
    int            emitted = 0;
    logic          prev_nres = 1'b0;
    int            mk = 0;
    int            cur_k = 0;
    int            run_cyc = 0;
    int            wait_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checker model: verdicts per candidate index, plus the result sink's ready.
    initial begin
        nlfsr_found   = 1'b0;
        nlfsr_failure = 1'b0;
        cand_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res) begin
                mk = 0; run_cyc = 0; wait_cnt = 0;
                nlfsr_found = 1'b0; nlfsr_failure = 1'b0; cand_ready = 1'b0;
            end else begin
                if (nlfsr_res) begin
                    nlfsr_found = 1'b0; nlfsr_failure = 1'b0; run_cyc = 0;
                    if (busy) begin
                        cur_k = mk;
                        mk++;
                    end
                end else if (nlfsr_ena) begin
                    run_cyc++;
                    if (run_cyc == 2 && cur_k < 9) begin
                        nlfsr_found   = cur_found_m[cur_k];
                        nlfsr_failure = cur_fail_m[cur_k];
                        if (cur_found_m[cur_k]) cand_q.push_back(exp_codes[cur_k]);
                    end
                end
                if (cand_valid) begin
                    if (wait_cnt < cur_hold) begin
                        cand_ready = 1'b0;
                        wait_cnt++;
                    end else begin
                        cand_ready = 1'b1;
                    end
                end else begin
                    cand_ready = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    // Output monitor: checker reset pulses and the candidate stream.
    initial begin
        forever begin
            @(negedge clk);
            if (nlfsr_res && busy) begin
                nres_cnt++;
                chk("nres_width", {31'd0, prev_nres}, 0);
                if (exp_nres.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL nres_taps: unexpected pulse with taps %0h, none expected", cand_taps);
                end else begin
                    chk("nres_taps", cand_taps, exp_nres.pop_front());
                end
            end
            prev_nres = nlfsr_res && busy;
            if (cand_valid) begin
                if (cand_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cand_taps: unexpected candidate %0h, none expected", cand_taps);
                end else begin
                    chk("cand_taps", cand_taps, cand_q[0]);
                    if (cand_ready) begin
                        void'(cand_q.pop_front());
                        emitted++;
                    end
                end
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        foreach (exp_codes[i]) exp_nres.push_back(exp_codes[i]);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int nb, eb, n;
        res = 1'b1;
        start = 1'b0;
        nlfsr_state = 4'hF;
        for (int c = 0; c < 256; c++) begin
            logic [7:0] cv;
            cv = c[7:0];
            if (cv[1:0] != 0 && cv[5:4] != 0 && cv[1:0] < cv[3:2] && cv[5:4] < cv[7:6])
                exp_codes.push_back(cv);
        end

        tbl[0] = '{9'h000,       9'h1FF,       0,  0};
        tbl[1] = '{9'h1FF,       9'h000,       0,  9};
        tbl[2] = '{9'b000000100, 9'b111111011, 20, 1};
        tbl[3] = '{9'b000010000, 9'h1FF,       0,  1};
        tbl[4] = '{9'b100000001, 9'b011111110, 3,  2};
        tbl[5] = '{9'b101010101, 9'h1FF,       1,  5};

        for (int r = 0; r < 6; r++) begin
            cur_found_m = tbl[r].found_m;
            cur_fail_m  = tbl[r].fail_m;
            cur_hold    = tbl[r].hold;
            @(negedge clk);
            res = 1'b1;
            repeat (2) @(negedge clk);
            chk($sformatf("row%0d_rst_nlfsr_res", r), nlfsr_res, 1);
            chk($sformatf("row%0d_rst_busy", r), busy, 0);
            chk($sformatf("row%0d_rst_done", r), done, 0);
            chk($sformatf("row%0d_rst_found_cnt", r), found_cnt, 0);
            chk($sformatf("row%0d_rst_cand_valid", r), cand_valid, 0);
            chk($sformatf("row%0d_rst_feedback", r), feedback, 0);
            res = 1'b0;
            nb = nres_cnt;
            eb = emitted;
            start_run();
            n = 0;
            while (!done && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("row%0d_done", r), done, 1);
            chk($sformatf("row%0d_busy_at_done", r), busy, 0);
            chk($sformatf("row%0d_found_cnt", r), found_cnt, tbl[r].exp_found);
            chk($sformatf("row%0d_nres_pulses", r), nres_cnt - nb, 9);
            chk($sformatf("row%0d_emitted", r), emitted - eb, tbl[r].exp_found);
            chk($sformatf("row%0d_cand_left", r), cand_q.size(), 0);
        end

        // Checker that never answers: RUN must hold; feedback of taps {2,1,2,1} is s[1]|s[2].
        cur_found_m = '0;
        cur_fail_m  = '0;
        cur_hold    = 0;
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        start_run();
        n = 0;
        while (!nlfsr_ena && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("stall_run_reached", nlfsr_ena, 1);
        for (int v = 0; v < 16; v++) begin
            logic [3:0] s;
            s = v[3:0];
            nlfsr_state = s;
            #1;
            chk($sformatf("feedback_%0h", s), feedback, s[1] | s[2]);
            @(negedge clk);
        end
        repeat (100) @(negedge clk);
        chk("stall_busy", busy, 1);
        chk("stall_ena", nlfsr_ena, 1);
        chk("stall_selector_done", selector_done, 1);
        chk("stall_done", done, 0);

        // Reset while in RUN aborts at once with no candidate output.
        nlfsr_state = 4'hF;
        res = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_nlfsr_res", nlfsr_res, 1);
        chk("abort_ena", nlfsr_ena, 0);
        chk("abort_selector_done", selector_done, 0);
        chk("abort_cand_valid", cand_valid, 0);
        chk("abort_feedback", feedback, 0);
        res = 1'b0;
        eb = emitted;
        repeat (30) @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_no_output", emitted - eb, 0);
        while (exp_nres.size() != 0) void'(exp_nres.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
